// File: rtl/data_memory_responder.sv
// Data-memory responder: latches one request, waits WAIT_STATES cycles, accesses a word array, pulses Ready/Err.
// Optional build macro MEM_WRITE_PROTECT_EN makes in-range word addresses below PROT_LIMIT read-only.
`timescale 1ns/1ps
module data_memory_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1,
  parameter int PROT_LIMIT  = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        RW,
  input  logic [31:0] address_in,
  input  logic [31:0] RAM_in,
  output logic [31:0] RAM_out,
  output logic        Ready,
  output logic        Err,
  output logic        Busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ram_out_q, ram_out_d;
  logic        rw_q, rw_d, ready_q, ready_d, err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic              access, acc_rw, range_err, prot_err, mem_we;
  logic [31:0]       acc_addr, acc_data;
  logic [ADDR_W-1:0] widx;

  // With no wait states the access happens on the accept edge, so use the live inputs.
  always_comb begin
    acc_addr = addr_q;
    acc_data = wdata_q;
    acc_rw   = rw_q;
    if (WAIT_STATES == 0 && state_q == S_IDLE) begin
      acc_addr = address_in;
      acc_data = RAM_in;
      acc_rw   = RW;
    end
  end

  assign range_err = (acc_addr >> ADDR_W) != 32'd0;
  assign widx      = acc_addr[ADDR_W-1:0];

`ifdef MEM_WRITE_PROTECT_EN
  assign prot_err = !acc_rw && (acc_addr < 32'(PROT_LIMIT));
`else
  logic unused_prot_limit;
  assign unused_prot_limit = (PROT_LIMIT != 0);
  assign prot_err          = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    ram_out_d = ram_out_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    access    = 1'b0;
    case (state_q)
      S_IDLE: if (Req) begin
        addr_d  = address_in;
        rw_d    = RW;
        wdata_d = RAM_in;
        if (WAIT_STATES == 0) access = 1'b1;
        else begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: if (cnt_q == 4'd0) access = 1'b1;
              else cnt_d = cnt_q - 4'd1;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (access) begin
      state_d = S_RESP;
      ready_d = 1'b1;
      if (range_err) begin
        err_d     = 1'b1;
        ram_out_d = 32'd0;
      end else if (acc_rw) ram_out_d = mem[widx];
      else if (prot_err)   err_d     = 1'b1;
    end
  end

  // Reset gates the write so a request seen during reset never lands in the array.
  assign mem_we = access && !acc_rw && !range_err && !prot_err && !Reset;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 32'd0;
      rw_q      <= 1'b0;
      wdata_q   <= 32'd0;
      ram_out_q <= 32'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      ram_out_q <= ram_out_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[widx] <= acc_data;
  end

  assign RAM_out = ram_out_q;
  assign Ready   = ready_q;
  assign Err     = err_q;
  assign Busy    = (state_q != S_IDLE);

endmodule
